// File: rtl/pht_updater.sv
// pht_updater: write-side controller for the pattern history table.
// Sweeps every entry to INIT_VALUE after reset or clear, then converts
// resolved-branch reports into 2-bit saturating-counter writes, correcting
// stale fetch-time counters from a short history of recent updates.
module pht_updater #(
  parameter int unsigned WADDR_WIDTH = 13,
  parameter logic [1:0]  INIT_VALUE  = 2'd1,
  parameter int unsigned FWD_DEPTH   = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   upd_valid,
  output logic                   upd_ready,
  input  logic [WADDR_WIDTH-1:0] upd_index,
  input  logic [1:0]             upd_ctr,
  input  logic                   upd_taken,
  output logic                   init_done,
  output logic                   pht_wen,
  output logic [WADDR_WIDTH-1:0] pht_waddr,
  output logic [1:0]             pht_wdata
);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t                 state, state_next;
  logic [WADDR_WIDTH-1:0] ptr, ptr_next;
  // Set once the last address has been written, so the pointer never
  // counts past max and the following edge moves to RUN.
  logic                   sweep_end, sweep_end_next;

  logic                   wen_next;
  logic [WADDR_WIDTH-1:0] waddr_next;
  logic [1:0]             wdata_next;

  // Forwarding history; slot 0 is the newest accepted update.
  logic [FWD_DEPTH-1:0]                  fwd_valid;
  logic [FWD_DEPTH-1:0][WADDR_WIDTH-1:0] fwd_index;
  logic [FWD_DEPTH-1:0][1:0]             fwd_ctr;

  logic       accept;
  logic       hist_push;
  logic       hist_flush;
  logic       fwd_hit;
  logic [1:0] base_ctr;
  logic [1:0] new_ctr;

  assign init_done = (state == ST_RUN);
  assign upd_ready = (state == ST_RUN) && !clear;
  assign accept    = upd_valid && upd_ready;

  // Base counter: newest matching history entry, else the fetch-time value.
  always_comb begin
    base_ctr = upd_ctr;
    fwd_hit  = 1'b0;
    for (int unsigned i = 0; i < FWD_DEPTH; i++) begin
      if (!fwd_hit && fwd_valid[i] && (fwd_index[i] == upd_index)) begin
        base_ctr = fwd_ctr[i];
        fwd_hit  = 1'b1;
      end
    end
  end

  // Saturating increment/decrement of the base counter.
  always_comb begin
    if (upd_taken) begin
      new_ctr = (base_ctr == 2'd3) ? 2'd3 : base_ctr + 2'd1;
    end else begin
      new_ctr = (base_ctr == 2'd0) ? 2'd0 : base_ctr - 2'd1;
    end
  end

  // Next-state and next write-port values for the INIT/RUN controller.
  always_comb begin
    state_next     = state;
    ptr_next       = ptr;
    sweep_end_next = sweep_end;
    wen_next       = 1'b0;
    waddr_next     = pht_waddr;
    wdata_next     = pht_wdata;
    hist_push      = 1'b0;
    hist_flush     = 1'b0;
    case (state)
      ST_INIT: begin
        if (sweep_end) begin
          state_next     = ST_RUN;
          ptr_next       = '0;
          sweep_end_next = 1'b0;
        end else begin
          wen_next   = 1'b1;
          waddr_next = ptr;
          wdata_next = INIT_VALUE;
          if (ptr == '1) begin
            sweep_end_next = 1'b1;
          end else begin
            ptr_next = ptr + 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (clear) begin
          state_next     = ST_INIT;
          ptr_next       = '0;
          sweep_end_next = 1'b0;
          hist_flush     = 1'b1;
        end else if (accept) begin
          wen_next   = (new_ctr != base_ctr);
          waddr_next = upd_index;
          wdata_next = new_ctr;
          hist_push  = 1'b1;
        end
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  // Controller state and registered PHT write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_INIT;
      ptr       <= '0;
      sweep_end <= 1'b0;
      pht_wen   <= 1'b0;
      pht_waddr <= '0;
      pht_wdata <= '0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      sweep_end <= sweep_end_next;
      pht_wen   <= wen_next;
      pht_waddr <= waddr_next;
      pht_wdata <= wdata_next;
    end
  end

  // Forwarding history: shift in every accepted update, drop all on clear.
  always_ff @(posedge clock) begin
    if (reset || hist_flush) begin
      fwd_valid <= '0;
    end else if (hist_push) begin
      for (int unsigned i = FWD_DEPTH - 1; i > 0; i--) begin
        fwd_valid[i] <= fwd_valid[i-1];
        fwd_index[i] <= fwd_index[i-1];
        fwd_ctr[i]   <= fwd_ctr[i-1];
      end
      fwd_valid[0] <= 1'b1;
      fwd_index[0] <= upd_index;
      fwd_ctr[0]   <= new_ctr;
    end
  end

endmodule

// File: tb/tb_pht_updater.sv
// tb_pht_updater: directed table-driven bench for pht_updater (4-bit address).
module tb_pht_updater;

  localparam int unsigned AW = 4;
  localparam int unsigned NENT = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          clear;
  logic          upd_valid;
  logic          upd_ready;
  logic [AW-1:0] upd_index;
  logic [1:0]    upd_ctr;
  logic          upd_taken;
  logic          init_done;
  logic          pht_wen;
  logic [AW-1:0] pht_waddr;
  logic [1:0]    pht_wdata;

  int checks   = 0;
  int failures = 0;

  pht_updater #(
    .WADDR_WIDTH (AW),
    .INIT_VALUE  (2'd1),
    .FWD_DEPTH   (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .upd_index (upd_index),
    .upd_ctr   (upd_ctr),
    .upd_taken (upd_taken),
    .init_done (init_done),
    .pht_wen   (pht_wen),
    .pht_waddr (pht_waddr),
    .pht_wdata (pht_wdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          v;
    logic [AW-1:0] idx;
    logic [1:0]    ctr;
    logic          tk;
    logic          ew;
    logic [1:0]    ed;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expect a full 16-address sweep; optionally pulse clear at one address.
  task automatic expect_sweep(input string tag, input int clear_at);
    for (int i = 0; i < NENT; i++) begin
      clear = (i == clear_at);
      tick();
      check({tag, "_wen"}, pht_wen, 1);
      check({tag, "_waddr"}, pht_waddr, i);
      check({tag, "_wdata"}, pht_wdata, 1);
      check({tag, "_init_done"}, init_done, 0);
      check({tag, "_ready"}, upd_ready, 0);
    end
    clear = 1'b0;
  endtask

  task automatic expect_run_entry(input string tag);
    tick();
    check({tag, "_wen"}, pht_wen, 0);
    check({tag, "_init_done"}, init_done, 1);
    check({tag, "_ready"}, upd_ready, 1);
  endtask

  task automatic do_update(input string tag, input logic [AW-1:0] idx, input logic [1:0] ctr,
                           input logic tk, input logic ew, input logic [1:0] ed);
    upd_valid = 1'b1;
    upd_index = idx;
    upd_ctr   = ctr;
    upd_taken = tk;
    tick();
    upd_valid = 1'b0;
    check({tag, "_wen"}, pht_wen, ew);
    if (ew) begin
      check({tag, "_waddr"}, pht_waddr, idx);
      check({tag, "_wdata"}, pht_wdata, ed);
    end
  endtask

  initial begin
    //            v  idx  ctr  tk  ew  ed
    vecs[0]  = '{1, 4'd5, 2'd1, 1, 1, 2'd2};  // basic increment
    vecs[1]  = '{1, 4'd7, 2'd3, 1, 0, 2'd3};  // saturated taken
    vecs[2]  = '{1, 4'd9, 2'd0, 0, 0, 2'd0};  // saturated not-taken
    vecs[3]  = '{0, 4'd0, 2'd0, 0, 0, 2'd0};  // idle
    vecs[4]  = '{1, 4'd3, 2'd1, 1, 1, 2'd2};  // forwarding chain
    vecs[5]  = '{1, 4'd3, 2'd1, 1, 1, 2'd3};
    vecs[6]  = '{1, 4'd3, 2'd1, 1, 0, 2'd3};
    vecs[7]  = '{1, 4'd12, 2'd0, 0, 0, 2'd0}; // flush history of index 3
    vecs[8]  = '{1, 4'd13, 2'd0, 0, 0, 2'd0};
    vecs[9]  = '{1, 4'd3, 2'd1, 1, 1, 2'd2};  // eviction sequence
    vecs[10] = '{1, 4'd4, 2'd2, 0, 1, 2'd1};
    vecs[11] = '{1, 4'd6, 2'd1, 1, 1, 2'd2};
    vecs[12] = '{1, 4'd3, 2'd1, 1, 1, 2'd2};  // index 3 evicted: base = upd_ctr
    vecs[13] = '{1, 4'd8, 2'd0, 1, 1, 2'd1};  // match in older slot
    vecs[14] = '{1, 4'd2, 2'd0, 1, 1, 2'd1};
    vecs[15] = '{1, 4'd8, 2'd0, 1, 1, 2'd2};
    vecs[16] = '{1, 4'd1, 2'd3, 0, 1, 2'd2};  // not-taken forwarding
    vecs[17] = '{1, 4'd1, 2'd3, 0, 1, 2'd1};
    vecs[18] = '{1, 4'd1, 2'd3, 0, 1, 2'd0};
    vecs[19] = '{1, 4'd1, 2'd3, 0, 0, 2'd0};
    vecs[20] = '{0, 4'd1, 2'd3, 0, 0, 2'd0};  // idle keeps history
    vecs[21] = '{1, 4'd1, 2'd3, 1, 1, 2'd1};  // base 0 from history
    vecs[22] = '{1, 4'd15, 2'd2, 1, 1, 2'd3};
    vecs[23] = '{1, 4'd0, 2'd3, 0, 1, 2'd2};

    reset = 1'b1; clear = 1'b0; upd_valid = 1'b1;
    upd_index = 4'd5; upd_ctr = 2'd1; upd_taken = 1'b1;

    tick();
    check("rst_wen", pht_wen, 0);
    check("rst_waddr", pht_waddr, 0);
    check("rst_wdata", pht_wdata, 0);
    check("rst_init_done", init_done, 0);
    check("rst_ready", upd_ready, 0);

    reset = 1'b0;
    expect_sweep("sweep0", -1);
    upd_valid = 1'b0;
    expect_run_entry("run0");
    tick();
    check("run0_no_stored_update", pht_wen, 0);

    for (int i = 0; i < NV; i++) begin
      check($sformatf("vec%0d_ready", i), upd_ready, 1);
      upd_valid = vecs[i].v;
      upd_index = vecs[i].idx;
      upd_ctr   = vecs[i].ctr;
      upd_taken = vecs[i].tk;
      tick();
      check($sformatf("vec%0d_wen", i), pht_wen, vecs[i].ew);
      if (vecs[i].ew) begin
        check($sformatf("vec%0d_waddr", i), pht_waddr, vecs[i].idx);
        check($sformatf("vec%0d_wdata", i), pht_wdata, vecs[i].ed);
      end
    end
    upd_valid = 1'b0;

    // clear with an update offered: not accepted, sweep restarts.
    upd_valid = 1'b1; upd_index = 4'd5; upd_ctr = 2'd1; upd_taken = 1'b1;
    clear = 1'b1;
    #1;
    check("clr_ready_low", upd_ready, 0);
    tick();
    clear = 1'b0;
    check("clr_wen", pht_wen, 0);
    check("clr_init_done", init_done, 0);
    check("clr_ready", upd_ready, 0);
    expect_sweep("sweep1", 4);
    upd_valid = 1'b0;
    expect_run_entry("run1");

    do_update("pre_reset", 4'd14, 2'd1, 1'b1, 1'b1, 2'd2);

    // Clear into INIT, then reset at sweep address 9.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("part_waddr", pht_waddr, i);
    end
    reset = 1'b1;
    upd_valid = 1'b1;
    tick();
    reset = 1'b0;
    upd_valid = 1'b0;
    check("midrst_wen", pht_wen, 0);
    check("midrst_waddr", pht_waddr, 0);
    check("midrst_init_done", init_done, 0);
    expect_sweep("sweep2", -1);
    expect_run_entry("run2");

    do_update("post_flush", 4'd14, 2'd1, 1'b1, 1'b1, 2'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
